// File: rtl/eth_mac_pkg.sv
// Shared constants and types for the Ethernet MAC datapath (TX framer, later RX checker).
package eth_mac_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    PAD,
    FCS,
    DRAIN,
    IFG
  } tx_state_t;

  // FCS is the complemented CRC register, sent least-significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = ~crc;
    case (idx)
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 (reflected, poly 0xEDB88320) advance by one byte, LSB first.
// No register inside; the caller owns the CRC state and its init/complement.
module eth_crc32_d8
  import eth_mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  // Shift one data bit at a time through the reflected LFSR.
  always_comb begin
    crc_work = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_work[0] ^ data_in[i]) begin
        crc_work = (crc_work >> 1) ^ CRC32_POLY_REFL;
      end else begin
        crc_work = crc_work >> 1;
      end
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/eth_mac_tx.sv
// Ethernet MAC transmit framer: preamble/SFD insertion, optional minimum-length
// padding, CRC-32 FCS append and inter-frame gap, driving a byte-wide PHY port
// through a single registered valid/ready output stage.
// Build option: define ETH_TX_PAD_EN to pad short frames up to MIN_FRAME_LEN;
// without it short frames go straight to the FCS.
module eth_mac_tx
  import eth_mac_pkg::*;
#(
  parameter int PREAMBLE_LEN  = 7,
  parameter int MIN_FRAME_LEN = 60,
  parameter int IFG_CYCLES    = 12
) (
  input  logic       phy_tx_clk,
  input  logic       phy_tx_rstn,
  input  logic [7:0] mac_tdata_in,
  input  logic       mac_tvalid_in,
  output logic       mac_tready_out,
  input  logic       mac_tlast_in,
  input  logic       mac_tuser_in,
  output logic [7:0] phy_txd_out,
  output logic       phy_tvalid_out,
  input  logic       phy_tready_in,
  output logic       phy_terr_out
);

  localparam logic [7:0]  PRE_LEN_C  = 8'(PREAMBLE_LEN);
  localparam logic [15:0] MIN_LEN_C  = 16'(MIN_FRAME_LEN);
  localparam logic [7:0]  IFG_LAST_C = 8'(IFG_CYCLES - 1);
`ifdef ETH_TX_PAD_EN
  localparam logic PAD_EN_C = 1'b1;
`else
  localparam logic PAD_EN_C = 1'b0;
`endif

  tx_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;            // preamble / FCS / IFG sub-counter
  logic [15:0] byte_cnt_q, byte_cnt_d;  // DATA+PAD bytes sent, saturating
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;            // sticky upstream error for this frame
  logic [7:0]  txd_q, txd_d;
  logic        tvalid_q, tvalid_d;
  logic        terr_q, terr_d;

  logic        load;
  logic [7:0]  crc_data;
  logic [31:0] crc_next;
  logic [15:0] byte_cnt_inc;

  // Output stage may take a new byte when empty or when the PHY consumes the current one.
  assign load = !tvalid_q || phy_tready_in;

  assign byte_cnt_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 16'd1;

  // Pad bytes are zeros; otherwise the CRC sees the upstream byte.
  assign crc_data = (state_q == PAD) ? 8'h00 : mac_tdata_in;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (crc_data),
    .crc_out (crc_next)
  );

  assign phy_txd_out    = txd_q;
  assign phy_tvalid_out = tvalid_q;
  assign phy_terr_out   = terr_q;

  // Framer state, counters, CRC and output register.
  always_ff @(posedge phy_tx_clk or negedge phy_tx_rstn) begin
    if (!phy_tx_rstn) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      byte_cnt_q <= 16'd0;
      crc_q      <= CRC32_INIT;
      err_q      <= 1'b0;
      txd_q      <= 8'h00;
      tvalid_q   <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      err_q      <= err_d;
      txd_q      <= txd_d;
      tvalid_q   <= tvalid_d;
      terr_q     <= terr_d;
    end
  end

  // Next-state and next-output; everything holds unless the output stage can load.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    byte_cnt_d     = byte_cnt_q;
    crc_d          = crc_q;
    err_d          = err_q;
    txd_d          = txd_q;
    tvalid_d       = tvalid_q;
    terr_d         = terr_q;
    mac_tready_out = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          tvalid_d = 1'b0;
          txd_d    = 8'h00;
          terr_d   = 1'b0;
          if (mac_tvalid_in) begin
            txd_d      = ETH_PREAMBLE;
            tvalid_d   = 1'b1;
            cnt_d      = 8'd1;
            byte_cnt_d = 16'd0;
            crc_d      = CRC32_INIT;
            err_d      = 1'b0;
            state_d    = PREAMBLE;
          end
        end
      end

      PREAMBLE: begin
        if (load) begin
          tvalid_d = 1'b1;
          terr_d   = 1'b0;
          if (cnt_q < PRE_LEN_C) begin
            txd_d = ETH_PREAMBLE;
            cnt_d = cnt_q + 8'd1;
          end else begin
            txd_d   = ETH_SFD;
            cnt_d   = 8'd0;
            state_d = DATA;
          end
        end
      end

      DATA: begin
        mac_tready_out = load;
        if (load) begin
          tvalid_d = 1'b1;
          if (mac_tvalid_in) begin
            txd_d      = mac_tdata_in;
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_inc;
            err_d      = err_q | mac_tuser_in;
            terr_d     = err_q | mac_tuser_in;
            if (mac_tlast_in) begin
              cnt_d   = 8'd0;
              state_d = (PAD_EN_C && (byte_cnt_inc < MIN_LEN_C)) ? PAD : FCS;
            end
          end else begin
            // Upstream underrun: poison the frame with one errored byte, skip the FCS.
            txd_d   = 8'h00;
            terr_d  = 1'b1;
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end

      PAD: begin
        if (load) begin
          txd_d      = 8'h00;
          tvalid_d   = 1'b1;
          terr_d     = err_q;
          crc_d      = crc_next;
          byte_cnt_d = byte_cnt_inc;
          if (byte_cnt_inc >= MIN_LEN_C) begin
            cnt_d   = 8'd0;
            state_d = FCS;
          end
        end
      end

      FCS: begin
        if (load) begin
          txd_d    = fcs_byte(crc_q, cnt_q[1:0]);
          tvalid_d = 1'b1;
          terr_d   = err_q;
          if (cnt_q == 8'd3) begin
            cnt_d   = 8'd0;
            state_d = IFG;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      DRAIN: begin
        // Swallow the rest of the aborted frame. The tlast handshake is taken even
        // while the errored byte is still stalled; IFG then waits for that handshake.
        mac_tready_out = 1'b1;
        if (load) begin
          tvalid_d = 1'b0;
          txd_d    = 8'h00;
          terr_d   = 1'b0;
        end
        if (mac_tvalid_in && mac_tlast_in) begin
          cnt_d   = 8'd0;
          state_d = IFG;
        end
      end

      IFG: begin
        if (load) begin
          tvalid_d = 1'b0;
          txd_d    = 8'h00;
          terr_d   = 1'b0;
          err_d    = 1'b0;
          crc_d    = CRC32_INIT;
          if (cnt_q >= IFG_LAST_C) begin
            cnt_d   = 8'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
